// File: rtl/mul_pkg.sv
// Shared definitions for the multiply unit.
//   - FSM state encoding (IDLE/EXEC/DONE), kept as plain constants for
//     compatibility with existing decoders in the ALU datapath.
//   - Radix-4 Booth digit encoding and the window-to-digit decode.
//   - Iteration count helper: unsigned operands need one extra step to
//     consume the zero-extension bits.
package mul_pkg;

   localparam logic [1:0] IDLE = 2'b00;
   localparam logic [1:0] EXEC = 2'b01;
   localparam logic [1:0] DONE = 2'b10;

   typedef enum logic [2:0] {
      Zero = 3'd0,
      Pos1 = 3'd1,
      Pos2 = 3'd2,
      Neg1 = 3'd3,
      Neg2 = 3'd4
   } booth_digit_e;

   // Window is {b[2i+1], b[2i], b[2i-1]} of the extended multiplier.
   function automatic booth_digit_e booth_digit(input logic [2:0] window);
      booth_digit_e digit;
      unique case (window)
         3'b000, 3'b111: digit = Zero;
         3'b001, 3'b010: digit = Pos1;
         3'b011:         digit = Pos2;
         3'b100:         digit = Neg2;
         3'b101, 3'b110: digit = Neg1;
         default:        digit = Zero;
      endcase
      return digit;
   endfunction

   function automatic int unsigned iter_count(input int unsigned width, input logic is_signed);
      return is_signed ? (width / 2) : (width / 2 + 1);
   endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth partial-product generator (purely combinational).
// Ports:
//   window : 3-bit multiplier window {b[2i+1], b[2i], b[2i-1]}
//   mcand  : multiplicand already extended to WIDTH+2 bits
//   pp     : signed partial product digit * mcand, WIDTH+2 bits
// The two guard bits make mcand[MSB] equal mcand[MSB-1] in both modes, so
// doubling by a 1-bit shift cannot lose information.
module booth_r4_encoder
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [2:0]       window,
   input  logic [WIDTH+1:0] mcand,
   output logic [WIDTH+1:0] pp
);

   booth_digit_e digit;

   assign digit = booth_digit(window);

   always_comb begin
      pp = '0;
      unique case (digit)
         Zero:    pp = '0;
         Pos1:    pp = mcand;
         Pos2:    pp = mcand << 1;
         Neg1:    pp = -mcand;
         Neg2:    pp = -(mcand << 1);
         default: pp = '0;
      endcase
   end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Ports:
//   clk          : rising-edge clock
//   reset        : asynchronous active-high reset
//   multiplier   : multiplier operand, sampled on the start edge
//   multiplicand : multiplicand operand, sampled on the start edge
//   op_signed    : 1 = two's-complement, 0 = unsigned; sampled on start
//   op_start     : level start request (only honoured in IDLE)
//   op_clear     : synchronous clear back to IDLE, beats op_start
//   op_busy      : high while executing
//   op_done      : high while the product is held
//   result       : product, nonzero only while op_done is high
// Two multiplier bits are retired per cycle: WIDTH/2 cycles signed,
// WIDTH/2+1 unsigned.
module booth_r4_multiplier
   import mul_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   multiplier,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic               op_signed,
   input  logic               op_start,
   input  logic               op_clear,
   output logic               op_busy,
   output logic               op_done,
   output logic [2*WIDTH-1:0] result
);

   localparam int unsigned EW = WIDTH + 2;
   localparam int unsigned AW = 2 * WIDTH + 2;
   localparam int unsigned CW = $clog2(WIDTH / 2 + 1);

   if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_width_check
      $error("booth_r4_multiplier: WIDTH must be even and >= 4");
   end

   logic [1:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [EW-1:0]      mplr_q, mplr_d;
   logic               prev_q, prev_d;
   logic [EW-1:0]      mcand_q, mcand_d;
   logic               sgn_q, sgn_d;
   logic [AW-1:0]      acc_q, acc_d;
   logic [2*WIDTH-1:0] result_q, result_d;

   logic [EW-1:0]      mplr_ext, mcand_ext;
   logic [2:0]         window;
   logic [EW-1:0]      pp;
   logic [CW:0]        shamt;
   logic [AW-1:0]      pp_shifted;
   logic [AW-1:0]      acc_sum;
   logic [CW-1:0]      last_cnt;

   assign mplr_ext  = {{2{op_signed & multiplier[WIDTH-1]}}, multiplier};
   assign mcand_ext = {{2{op_signed & multiplicand[WIDTH-1]}}, multiplicand};

   // mplr_q is shifted right two bits per step, so the current window always
   // sits at the bottom; prev_q carries bit 2i-1 (zero on the first step).
   assign window = {mplr_q[1:0], prev_q};

   booth_r4_encoder #(
      .WIDTH(WIDTH)
   ) u_encoder (
      .window(window),
      .mcand (mcand_q),
      .pp    (pp)
   );

   assign shamt      = {cnt_q, 1'b0};
   assign pp_shifted = {{WIDTH{pp[EW-1]}}, pp} << shamt;
   assign acc_sum    = acc_q + pp_shifted;
   assign last_cnt   = CW'(iter_count(WIDTH, sgn_q) - 1);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mplr_d   = mplr_q;
      prev_d   = prev_q;
      mcand_d  = mcand_q;
      sgn_d    = sgn_q;
      acc_d    = acc_q;
      result_d = result_q;

      if (op_clear) begin
         state_d  = IDLE;
         cnt_d    = '0;
         mplr_d   = '0;
         prev_d   = 1'b0;
         mcand_d  = '0;
         sgn_d    = 1'b0;
         acc_d    = '0;
         result_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (op_start) begin
                  state_d = EXEC;
                  cnt_d   = '0;
                  mplr_d  = mplr_ext;
                  prev_d  = 1'b0;
                  mcand_d = mcand_ext;
                  sgn_d   = op_signed;
                  acc_d   = '0;
               end
            end
            EXEC: begin
               acc_d  = acc_sum;
               mplr_d = {{2{mplr_q[EW-1]}}, mplr_q[EW-1:2]};
               prev_d = mplr_q[1];
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == last_cnt) begin
                  state_d  = DONE;
                  result_d = acc_sum[2*WIDTH-1:0];
               end
            end
            DONE: begin
               // Hold the product until op_clear.
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         mplr_q   <= '0;
         prev_q   <= 1'b0;
         mcand_q  <= '0;
         sgn_q    <= 1'b0;
         acc_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mplr_q   <= mplr_d;
         prev_q   <= prev_d;
         mcand_q  <= mcand_d;
         sgn_q    <= sgn_d;
         acc_q    <= acc_d;
         result_q <= result_d;
      end
   end

   assign op_busy = (state_q == EXEC);
   assign op_done = (state_q == DONE);
   assign result  = result_q;

endmodule
